// File: rtl/rr_mux_arbiter_4.sv
// ============================================================================
// Module   : rr_mux_arbiter_4
// Brief    : Round-robin burst arbiter and 4:1 mux sequencer for one output
//            channel. Define ARB_TIMEOUT_EN to bound bursts to MAX_BEATS beats.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_mux_arbiter_4 #(
   parameter int DW        = 8,
   parameter int MAX_BEATS = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [3:0]    req,
   input  logic [3:0]    last,
   input  logic [DW-1:0] din0,
   input  logic [DW-1:0] din1,
   input  logic [DW-1:0] din2,
   input  logic [DW-1:0] din3,
   input  logic          out_ready,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   output logic [3:0]    gnt,
   output logic [1:0]    sel,
   output logic          busy
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   if (MAX_BEATS < 1) begin : g_bad_max_beats
      $error("MAX_BEATS must be at least 1");
   end

   state_t     state_q, state_d;
   logic [3:0] gnt_q, gnt_d;
   logic [1:0] sel_q, sel_d;
   logic [1:0] ptr_q, ptr_d;

   logic [1:0] pick;
   logic       found;
   logic [1:0] idx;
   logic       xfer;

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(MAX_BEATS + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          cnt_hit;
   assign cnt_hit = ((cnt_q + CW'(1)) == CW'(MAX_BEATS));
`endif

   assign busy      = (state_q == BURST);
   assign gnt       = gnt_q;
   assign sel       = sel_q;
   assign out_valid = busy & req[sel_q];
   assign out_last  = busy & last[sel_q];
   assign xfer      = out_valid & out_ready;

   always_comb begin
      out_data = din0;
      case (sel_q)
         2'd0:    out_data = din0;
         2'd1:    out_data = din1;
         2'd2:    out_data = din2;
         default: out_data = din3;
      endcase
   end

   // Search starts just after the last winner, so the last winner ranks lowest.
   always_comb begin
      pick  = ptr_q;
      found = 1'b0;
      idx   = ptr_q;
      for (int k = 1; k <= 4; k++) begin
         idx = ptr_q + 2'(k);
         if (!found && req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d = BURST;
               gnt_d   = 4'b0001 << pick;
               sel_d   = pick;
`ifdef ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         default: begin
            if (!req[sel_q] || (xfer && last[sel_q])) begin
               state_d = IDLE;
               gnt_d   = 4'b0000;
               ptr_d   = sel_q;
            end
`ifdef ARB_TIMEOUT_EN
            else if (xfer && cnt_hit) begin
               state_d = IDLE;
               gnt_d   = 4'b0000;
               ptr_d   = sel_q;
            end else if (xfer) begin
               cnt_d   = cnt_q + CW'(1);
            end
`endif
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= 4'b0000;
         sel_q   <= 2'd0;
         ptr_q   <= 2'd3;
`ifdef ARB_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_rr_mux_arbiter_4.sv
// ============================================================================
// Module   : tb_rr_mux_arbiter_4
// Brief    : Directed self-checking bench for rr_mux_arbiter_4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_mux_arbiter_4;

`ifdef ARB_TIMEOUT_EN
   localparam int MB = 4;
`else
   localparam int MB = 16;
`endif

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] last;
   logic [7:0] din0, din1, din2, din3;
   logic       out_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_last;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       busy;

   int checks;
   int errors;

   rr_mux_arbiter_4 #(.DW(8), .MAX_BEATS(MB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .last      (last),
      .din0      (din0),
      .din1      (din1),
      .din2      (din2),
      .din3      (din3),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .gnt       (gnt),
      .sel       (sel),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      tick();
      rst_n = 1'b0; req = 4'b0; last = 4'b0; out_ready = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      tick();
      rst_n = 1'b0; req = 4'b1111; last = 4'b0; out_ready = 1'b1;
      din0 = 8'h5A; din1 = 8'h11; din2 = 8'h22; din3 = 8'h33;
      #1;
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b want 0000", gnt); end
      checks++; if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d want 0", sel); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
      checks++; if (out_data !== 8'h5A) begin errors++; $display("FAIL reset_data got %h want 5a", out_data); end
      tick();
      tick();
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_hold_gnt got %b want 0000", gnt); end
      rst_n = 1'b1;
      tick();
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL reset_first_gnt got %b want 0001", gnt); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_first_busy got %b want 1", busy); end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      req = 4'b0100; last = 4'b0; out_ready = 1'b1;
      tick();
      checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL midrst_pre_gnt got %b want 0100", gnt); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (gnt !== 4'b0000 || sel !== 2'd0 || busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL midrst_async got gnt=%b sel=%0d busy=%b valid=%b want 0000/0/0/0", gnt, sel, busy, out_valid);
      end
      tick();
      rst_n = 1'b1; req = 4'b0;
   endtask

   task automatic test_single_burst();
      do_reset();
      req = 4'b0010; last = 4'b0; out_ready = 1'b1; din1 = 8'hA0;
      #1;
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_latency got %b want 0000", gnt); end
      tick();
      checks++; if (gnt !== 4'b0010 || sel !== 2'd1) begin errors++; $display("FAIL single_gnt got %b/%0d want 0010/1", gnt, sel); end
      checks++; if (out_valid !== 1'b1 || out_data !== 8'hA0 || out_last !== 1'b0) begin
         errors++; $display("FAIL single_beat0 got v=%b d=%h l=%b want 1/a0/0", out_valid, out_data, out_last);
      end
      tick();
      din1 = 8'hA1;
      #1;
      checks++; if (out_valid !== 1'b1 || out_data !== 8'hA1 || gnt !== 4'b0010) begin
         errors++; $display("FAIL single_beat1 got v=%b d=%h g=%b want 1/a1/0010", out_valid, out_data, gnt);
      end
      tick();
      din1 = 8'hA2; last = 4'b0010;
      #1;
      checks++; if (out_data !== 8'hA2 || out_last !== 1'b1) begin
         errors++; $display("FAIL single_beat2 got d=%h l=%b want a2/1", out_data, out_last);
      end
      tick();
      req = 4'b0; last = 4'b0;
      checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL single_release got %b/%b want 0000/0", gnt, busy); end
   endtask

   task automatic test_fairness();
      logic [3:0] exp;
      do_reset();
      req = 4'b1111; last = 4'b1111; out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         exp = 4'b0001 << (k % 4);
         tick();
         checks++; if (gnt !== exp) begin errors++; $display("FAIL fair_gnt%0d got %b want %b", k, gnt, exp); end
         tick();
         checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL fair_idle%0d got %b want 0000", k, gnt); end
      end
      req = 4'b0; last = 4'b0;
   endtask

   task automatic test_backpressure();
      do_reset();
      req = 4'b0001; last = 4'b0; out_ready = 1'b1; din0 = 8'hB0;
      tick();
      checks++; if (out_data !== 8'hB0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_beat0 got %h/%b want b0/1", out_data, out_valid); end
      tick();
      din0 = 8'hB1; out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k == 1) req = 4'b1111;
         #1;
         checks++; if (out_valid !== 1'b1 || out_data !== 8'hB1 || sel !== 2'd0 || gnt !== 4'b0001) begin
            errors++; $display("FAIL bp_stall%0d got v=%b d=%h s=%0d g=%b want 1/b1/0/0001", k, out_valid, out_data, sel, gnt);
         end
         tick();
      end
      out_ready = 1'b1; last = 4'b0001;
      #1;
      checks++; if (out_data !== 8'hB1 || out_last !== 1'b1) begin errors++; $display("FAIL bp_resume got %h/%b want b1/1", out_data, out_last); end
      tick();
      last = 4'b0;
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL bp_release got %b want 0000", gnt); end
      tick();
      checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL bp_next got %b want 0010", gnt); end
      req = 4'b0;
   endtask

   task automatic test_abandon();
      do_reset();
      req = 4'b0100; last = 4'b0; out_ready = 1'b0;
      tick();
      checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL abandon_gnt got %b want 0100", gnt); end
      req = 4'b1100;
      tick();
      checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL abandon_hold got %b want 0100", gnt); end
      req = 4'b1000;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abandon_valid got %b want 0", out_valid); end
      tick();
      checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL abandon_idle got %b/%b want 0000/0", gnt, busy); end
      tick();
      checks++; if (gnt !== 4'b1000 || sel !== 2'd3) begin errors++; $display("FAIL abandon_next got %b/%0d want 1000/3", gnt, sel); end
      req = 4'b0;
   endtask

`ifdef ARB_TIMEOUT_EN
   task automatic test_timeout();
      do_reset();
      req = 4'b0011; last = 4'b0; out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++; if (gnt !== 4'b0001 || out_last !== 1'b0) begin
            errors++; $display("FAIL tmo_beat%0d got g=%b l=%b want 0001/0", k, gnt, out_last);
         end
      end
      tick();
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL tmo_release got %b want 0000", gnt); end
      tick();
      checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL tmo_next got %b want 0010", gnt); end
      last = 4'b0010;
      tick();
      last = 4'b0;
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL tmo_idle2 got %b want 0000", gnt); end
      tick();
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL tmo_regrant got %b want 0001", gnt); end
      req = 4'b0;
   endtask
`else
   task automatic test_unbounded();
      do_reset();
      req = 4'b0011; last = 4'b0; out_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL unb_beat%0d got %b want 0001", k, gnt); end
      end
      last = 4'b0001;
      tick();
      last = 4'b0;
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL unb_release got %b want 0000", gnt); end
      tick();
      checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL unb_next got %b want 0010", gnt); end
      req = 4'b0;
   endtask
`endif

   initial begin
      checks = 0; errors = 0;
      rst_n = 1'b0; req = 4'b0; last = 4'b0; out_ready = 1'b0;
      din0 = 8'h00; din1 = 8'h00; din2 = 8'h00; din3 = 8'h00;
      test_reset();
      test_reset_mid_burst();
      test_single_burst();
      test_fairness();
      test_backpressure();
      test_abandon();
`ifdef ARB_TIMEOUT_EN
      test_timeout();
`else
      test_unbounded();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
